i2c_txn_arbiter: RTL and testbench

Shares the single i2c_master among NUM_REQ on-chip requesters and sequences each single-byte transaction. Sequencing covers start, address/data phase, stop hold, response and timeout. Sits between requester blocks and the i2c_master command inputs (start, stop, rw, addr, w_data). Uses round-robin arbitration so no requester starves.

---
 rtl/i2c_txn_arbiter.sv | 153 +++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NUM_REQ requesters and
// sequences each single-byte transaction through start, data, stop hold and response.
module i2c_txn_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_CYC   = 4096,
  parameter int STOP_HOLD_CYC = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic [1:0]             rsp_err,
  output logic                   busy,
  output logic                   m_start,
  output logic                   m_stop,
  output logic                   m_rw,
  output logic [6:0]             m_addr,
  output logic [7:0]             m_wdata,
  input  logic                   m_done,
  input  logic                   m_nack,
  input  logic [7:0]             m_rdata
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int SW = (STOP_HOLD_CYC > 1) ? $clog2(STOP_HOLD_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, XFER, STOP, RESP} state_t;

  state_t               state, next_state;
  logic [GW-1:0]        ptr, grant, pick;
  logic                 pick_found;
  logic                 pick_rw;
  logic [6:0]           pick_addr;
  logic [7:0]           pick_wdata;
  logic [TW-1:0]        tmo_cnt;
  logic [SW-1:0]        stop_cnt;
  logic [NUM_REQ-1:0]   req_ready_d, rsp_valid_d;
  logic                 busy_d, m_start_d, m_stop_d;

  // Round-robin scan starting at ptr, wrapping past the top requester.
  always_comb begin
    int idx;
    pick       = ptr;
    pick_found = 1'b0;
    idx        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_found && req_valid[GW'(idx)]) begin
        pick       = GW'(idx);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_rw    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == pick) begin
        pick_rw    = req_rw[i];
        pick_addr  = req_addr[7*i +: 7];
        pick_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  // State register plus the latched command fields, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      grant     <= '0;
      tmo_cnt   <= '0;
      stop_cnt  <= '0;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_stop    <= 1'b0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state     <= next_state;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      busy      <= busy_d;
      m_start   <= m_start_d;
      m_stop    <= m_stop_d;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant   <= pick;
            m_rw    <= pick_rw;
            m_addr  <= pick_addr;
            m_wdata <= pick_wdata;
            tmo_cnt <= '0;
          end
        end
        XFER: begin
          stop_cnt <= '0;
          if (m_done) begin
            rsp_rdata <= m_rw ? m_rdata : 8'h00;
            rsp_err   <= {1'b0, m_nack};
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_rdata <= 8'h00;
            rsp_err   <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        STOP: stop_cnt <= stop_cnt + SW'(1);
        RESP: ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = XFER;
      XFER:    if (m_done || tmo_cnt == TMO_LAST) next_state = STOP;
      STOP:    if (stop_cnt == STOP_LAST) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear registered.
  always_comb begin
    req_ready_d = '0;
    rsp_valid_d = '0;
    busy_d      = (next_state != IDLE);
    m_start_d   = (next_state == XFER);
    m_stop_d    = (next_state == STOP);
    if (state == IDLE && next_state == XFER) req_ready_d[pick] = 1'b1;
    if (state == STOP && next_state == RESP) rsp_valid_d[grant] = 1'b1;
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed scenarios plus randomized
// transactions compared against a round-robin reference model.
module tb_i2c_txn_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int TIMEOUT_CYC   = 16;
  localparam int STOP_HOLD_CYC = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_rw;
  logic [7*NUM_REQ-1:0]  req_addr;
  logic [8*NUM_REQ-1:0]  req_wdata;
  logic [NUM_REQ-1:0]    req_ready, rsp_valid;
  logic [7:0]            rsp_rdata;
  logic [1:0]            rsp_err;
  logic                  busy, m_start, m_stop, m_rw;
  logic [6:0]            m_addr;
  logic [7:0]            m_wdata;
  logic                  m_done, m_nack;
  logic [7:0]            m_rdata;

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;

  i2c_txn_arbiter #(
    .NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT_CYC), .STOP_HOLD_CYC(STOP_HOLD_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .m_start(m_start), .m_stop(m_stop), .m_rw(m_rw), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int expected_grant(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = (model_ptr + i) % NUM_REQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic scramble_fields();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[7*i +: 7]  = 7'($urandom);
      req_wdata[8*i +: 8] = 8'($urandom);
    end
    req_rw = NUM_REQ'($urandom);
  endtask

  // One complete transaction; done_cycle is the XFER cycle (1-based) carrying m_done.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] rw,
                               input int done_cycle, input bit nack, input logic [7:0] rdata,
                               input bit use_fix, input logic [6:0] fix_addr, input logic [7:0] fix_wdata);
    int g, cyc, stop_len, exp_len;
    bit quiet_bad, hold_bad;
    logic [6:0] exp_addr;
    logic [7:0] exp_wdata, exp_rdata;
    logic       exp_rw;
    logic [1:0] exp_err;

    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[7*i +: 7]  = use_fix ? fix_addr  : 7'($urandom);
      req_wdata[8*i +: 8] = use_fix ? fix_wdata : 8'($urandom);
    end
    req_rw    = rw;
    req_valid = mask;
    g         = expected_grant(mask);
    exp_addr  = req_addr[7*g +: 7];
    exp_wdata = req_wdata[8*g +: 8];
    exp_rw    = rw[g];
    if (done_cycle <= TIMEOUT_CYC) begin
      exp_len   = done_cycle;
      exp_err   = nack ? 2'b01 : 2'b00;
      exp_rdata = exp_rw ? rdata : 8'h00;
    end else begin
      exp_len   = TIMEOUT_CYC;
      exp_err   = 2'b10;
      exp_rdata = 8'h00;
    end

    tick();
    checkOutput("grant_ready", 32'(req_ready), 32'(1) << g);
    checkOutput("grant_busy", 32'(busy), 32'd1);
    req_valid[g] = 1'b0;
    scramble_fields();

    cyc = 0; quiet_bad = 1'b0; hold_bad = 1'b0;
    while (m_start === 1'b1 && cyc < 4*TIMEOUT_CYC) begin
      cyc++;
      if (m_addr !== exp_addr || m_wdata !== exp_wdata || m_rw !== exp_rw ||
          m_stop !== 1'b0 || busy !== 1'b1) hold_bad = 1'b1;
      if ((cyc > 1 && req_ready !== '0) || rsp_valid !== '0) quiet_bad = 1'b1;
      if (cyc == done_cycle) begin
        m_done = 1'b1; m_nack = nack; m_rdata = rdata;
      end
      tick();
      m_done = 1'b0; m_nack = 1'($urandom); m_rdata = 8'($urandom);
    end
    checkOutput("xfer_len", 32'(cyc), 32'(exp_len));
    checkOutput("xfer_fields_held", 32'(hold_bad), 32'd0);

    stop_len = 0;
    while (m_stop === 1'b1 && stop_len < 4*STOP_HOLD_CYC) begin
      stop_len++;
      if (m_start !== 1'b0 || m_addr !== exp_addr || m_wdata !== exp_wdata ||
          m_rw !== exp_rw || busy !== 1'b1) hold_bad = 1'b1;
      if (req_ready !== '0 || rsp_valid !== '0) quiet_bad = 1'b1;
      tick();
    end
    checkOutput("stop_len", 32'(stop_len), 32'(STOP_HOLD_CYC));
    checkOutput("stop_fields_held", 32'(hold_bad), 32'd0);
    checkOutput("no_stray_pulses", 32'(quiet_bad), 32'd0);

    checkOutput("rsp_valid", 32'(rsp_valid), 32'(1) << g);
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    checkOutput("resp_quiet", 32'({req_ready, m_stop, m_start, busy}), 32'd1);
    model_ptr = (g + 1) % NUM_REQ;
    req_valid = '0;
    tick();
    checkOutput("idle_after", 32'({busy, rsp_valid}), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    m_done = 1'b0; m_nack = 1'b0; m_rdata = '0;
    tick(); tick(); tick();
    checkOutput("reset_ctrl", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, busy, m_start, m_stop, m_rw}), 32'd0);
    checkOutput("reset_fields", 32'({m_addr, m_wdata}), 32'd0);
    reset = 1'b1;
    tick();
    checkOutput("reset_release_idle", 32'({busy, req_ready}), 32'd0);

    $display("[TB] round-robin with all requesters active");
    for (int t = 0; t < 5; t++) applyStimulus(4'b1111, 4'b0000, 5 + t, 1'b0, 8'h11, 1'b0, 7'h0, 8'h0);
    applyStimulus(4'b1111, 4'b0000, 3, 1'b0, 8'h00, 1'b0, 7'h0, 8'h0);
    applyStimulus(4'b1111, 4'b0000, 3, 1'b0, 8'h00, 1'b0, 7'h0, 8'h0);
    applyStimulus(4'b0101, 4'b0000, 4, 1'b0, 8'h00, 1'b0, 7'h0, 8'h0);
    checkOutput("rr_wrap_ptr_model", 32'(model_ptr), 32'd1);

    $display("[TB] write to 0x55");
    applyStimulus(4'b0001, 4'b0000, 10, 1'b0, 8'h99, 1'b1, 7'h55, 8'hAA);

    $display("[TB] read with nack");
    applyStimulus(4'b0100, 4'b0100, 7, 1'b1, 8'h3C, 1'b1, 7'h55, 8'h00);

    $display("[TB] timeout");
    applyStimulus(4'b1000, 4'b1000, 1000, 1'b0, 8'h77, 1'b0, 7'h0, 8'h0);

    $display("[TB] m_done on the last timeout cycle");
    applyStimulus(4'b0010, 4'b0010, TIMEOUT_CYC, 1'b0, 8'hA5, 1'b0, 7'h0, 8'h0);

    m_done = 1'b1; m_nack = 1'b1; m_rdata = 8'hFF;
    tick();
    m_done = 1'b0; m_nack = 1'b0;
    checkOutput("idle_done_ignored", 32'({busy, rsp_valid, m_stop}), 32'd0);
    tick();
    checkOutput("idle_done_ignored_2", 32'({busy, rsp_valid, m_stop}), 32'd0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 12; t++) begin
      applyStimulus(NUM_REQ'($urandom_range(1, 15)), NUM_REQ'($urandom), $urandom_range(1, 20),
                    1'($urandom), 8'($urandom), 1'b0, 7'h0, 8'h0);
    end

    $display("[TB] reset during transfer");
    applyStimulus(4'b0010, 4'b0000, 2, 1'b0, 8'h00, 1'b0, 7'h0, 8'h0);
    req_addr[7*3 +: 7] = 7'h6B; req_wdata[8*3 +: 8] = 8'hC5; req_rw = 4'b1000;
    req_valid = 4'b1000;
    tick();
    checkOutput("abort_grant", 32'(req_ready), 32'h8);
    req_valid = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    checkOutput("abort_ctrl", 32'({req_ready, rsp_valid, rsp_rdata, rsp_err, busy, m_start, m_stop, m_rw}), 32'd0);
    checkOutput("abort_fields", 32'({m_addr, m_wdata}), 32'd0);
    reset = 1'b1;
    model_ptr = 0;
    tick();
    checkOutput("abort_no_resp", 32'({busy, rsp_valid, m_stop}), 32'd0);
    applyStimulus(4'b1010, 4'b0000, 4, 1'b0, 8'h00, 1'b0, 7'h0, 8'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
